// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding,
// checksum seed and a width helper.
package boot_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } loader_state_e;

    localparam logic [7:0] LOADER_CHECKSUM_INIT = 8'h00;

    // $clog2 that never yields a zero-width field (a single word still needs one address bit).
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader is the slave: it consumes bytes and drives the write port.
interface boot_loader_if #(
    parameter int ADDR_W = 1
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_write_en;
    logic [ADDR_W-1:0] imem_write_addr;
    logic [31:0]       imem_write_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_write_en, imem_write_addr, imem_write_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_write_en, imem_write_addr, imem_write_data
    );
endinterface

// File: rtl/boot_loader_byte_assembler.sv
// Packs four consecutive bytes into a little-endian 32-bit word; word_done
// fires combinationally with the fourth byte so the caller can register the write.
module boot_loader_byte_assembler (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o
);
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (byte_valid_i) begin
            idx_d  = idx_q + 2'd1;
            // Shifting in from the top leaves byte 0 in bits [7:0] after four bytes.
            word_d = {byte_i, word_q[31:8]};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_done_o = byte_valid_i && !clear_i && (idx_q == 2'd3);
    assign word_o      = word_q;

endmodule

// File: rtl/boot_loader.sv
// Streams a program image into instruction memory, verifies its XOR checksum and
// only then releases the core from reset.
//
//   state    | meaning
//   ST_LOAD  | accepting image bytes, writing one word per four bytes
//   ST_CHECK | image written, waiting for the checksum byte
//   ST_RUN   | image verified, core out of reset
//   ST_ERROR | bad checksum or stalled stream, waits for reload/reset
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter  int PROGRAM_INSTRUCTIONS = 64,
    parameter  int TIMEOUT_CYCLES       = 1000,
    localparam int ADDR_W               = clog2_min1(PROGRAM_INSTRUCTIONS)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              reload_i,
    boot_loader_if.slave      bus,
    output logic              core_reset_o,
    output logic              loaded_o,
    output logic              error_o,
    output logic [ADDR_W:0]   words_loaded_o
);
    localparam int WL_W   = ADDR_W + 1;
    localparam int IDLE_W = clog2_min1(TIMEOUT_CYCLES + 1);

    localparam logic [WL_W-1:0]   WORD_LAST = WL_W'(PROGRAM_INSTRUCTIONS - 1);
    localparam logic [WL_W-1:0]   WORD_ONE  = WL_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    loader_state_e     state_q, state_d;
    logic [WL_W-1:0]   words_q, words_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [7:0]        csum_q, csum_d;
    logic              started_q, started_d;
    logic              we_q, we_d;

    logic        accept;
    logic        last_write;
    logic        image_byte;
    logic        check_byte;
    logic        csum_ok;
    logic        idle_active;
    logic        timed_out;
    logic        word_done;
    logic [31:0] word;

    assign bus.in_ready = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !reload_i;
    assign accept       = bus.in_valid && bus.in_ready;

    // The cycle that writes the final word already counts as the checksum window.
    assign last_write  = (state_q == ST_LOAD) && we_q && (words_q == WORD_LAST);
    assign image_byte  = accept && (state_q == ST_LOAD) && !last_write;
    assign check_byte  = accept && !image_byte;
    assign csum_ok     = (bus.in_data == csum_q);
    assign idle_active = ((state_q == ST_LOAD) && started_q) || (state_q == ST_CHECK);
    assign timed_out   = idle_active && !accept && (idle_q == IDLE_LAST);

    boot_loader_byte_assembler u_assembler (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .clear_i      (reload_i),
        .byte_valid_i (image_byte),
        .byte_i       (bus.in_data),
        .word_done_o  (word_done),
        .word_o       (word)
    );

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        idle_d    = idle_q;
        csum_d    = csum_q;
        started_d = started_q;
        we_d      = 1'b0;

        if (reload_i) begin
            state_d   = ST_LOAD;
            words_d   = '0;
            idle_d    = '0;
            csum_d    = LOADER_CHECKSUM_INIT;
            started_d = 1'b0;
        end else begin
            if (we_q) begin
                words_d = words_q + WORD_ONE;
            end
            if (accept) begin
                idle_d = '0;
            end else if (idle_active) begin
                idle_d = idle_q + IDLE_ONE;
            end
            if (image_byte) begin
                csum_d    = csum_q ^ bus.in_data;
                started_d = 1'b1;
                we_d      = word_done;
            end

            case (state_q)
                ST_LOAD: begin
                    if (check_byte) begin
                        state_d = csum_ok ? ST_RUN : ST_ERROR;
                    end else if (timed_out) begin
                        state_d = ST_ERROR;
                    end else if (last_write) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (check_byte) begin
                        state_d = csum_ok ? ST_RUN : ST_ERROR;
                    end else if (timed_out) begin
                        state_d = ST_ERROR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_LOAD;
            words_q   <= '0;
            idle_q    <= '0;
            csum_q    <= LOADER_CHECKSUM_INIT;
            started_q <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            words_q   <= words_d;
            idle_q    <= idle_d;
            csum_q    <= csum_d;
            started_q <= started_d;
            we_q      <= we_d;
        end
    end

    // A reload landing on a strobe cycle cancels that write.
    assign bus.imem_write_en   = we_q && !reload_i;
    assign bus.imem_write_addr = words_q[ADDR_W-1:0];
    assign bus.imem_write_data = word;

    assign core_reset_o   = (state_q != ST_RUN);
    assign loaded_o       = (state_q == ST_RUN);
    assign error_o        = (state_q == ST_ERROR);
    assign words_loaded_o = words_q;

endmodule
